// File: rtl/code_entry.sv
// ---------------------------------------------------------------------------
// code_entry
//
// Keypad front end for a digital lock. Raw push buttons and a clear request
// are synchronised and debounced, button presses are turned into 2-bit digits
// and collected into a code buffer while the downstream lock FSM holds arm
// high. Once CODE_LEN digits are held the buffer is compared against the
// stored PASSWORD and the registered result is presented on correct.
//
// Ports
//   clk            in   1  single clock, rising edge
//   reset          in   1  asynchronous, active-low reset
//   btn            in   4  raw asynchronous push buttons (intended one-hot)
//   clear          in   1  raw asynchronous clear request
//   arm            in   1  synchronous, high while lock FSM is in INPUT
//   digit_valid    out  1  one-cycle pulse when a digit is accepted
//   digit          out  2  encoded accepted digit (valid with digit_valid)
//   invalid_press  out  1  one-cycle pulse on a multi-button press
//   digit_count    out  4  digits currently held, 0..CODE_LEN
//   seq_full       out  1  high while CODE_LEN digits are held
//   correct        out  1  high while full, buffer matches, no bad press
//   state_dbg      out  2  current FSM state (0 IDLE, 1 COLLECT, 2 FULL)
//
// Handshake: there is no back-pressure. digit_valid and invalid_press are
// single-cycle strobes with no ready; a consumer must sample them on the
// cycle they are high. seq_full/correct are levels held until arm drops,
// clear is seen, or reset.
// ---------------------------------------------------------------------------
module code_entry #(
    parameter int unsigned CODE_LEN  = 4,
    parameter logic [15:0] PASSWORD  = 16'b11_10_01_00,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn,
    input  logic       clear,
    input  logic       arm,
    output logic       digit_valid,
    output logic [1:0] digit,
    output logic       invalid_press,
    output logic [3:0] digit_count,
    output logic       seq_full,
    output logic       correct,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } state_e;

    localparam int unsigned     BW   = 2 * CODE_LEN;
    localparam logic [BW-1:0]   PW   = PASSWORD[BW-1:0];
    localparam logic [3:0]      LEN4 = 4'(CODE_LEN);
    localparam logic [7:0]      DB8  = 8'(DB_CYCLES);

    // -----------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is delayed two
    // clocks so every downstream flop leaves reset on a clean edge.
    // -----------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // -----------------------------------------------------------------------
    // Input synchronisers
    // -----------------------------------------------------------------------
    logic [3:0] btn_s1_q, btn_s2_q;
    logic       clr_s1_q, clr_s2_q;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            btn_s1_q <= 4'b0000;
            btn_s2_q <= 4'b0000;
            clr_s1_q <= 1'b0;
            clr_s2_q <= 1'b0;
        end else begin
            btn_s1_q <= btn;
            btn_s2_q <= btn_s1_q;
            clr_s1_q <= clear;
            clr_s2_q <= clr_s1_q;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce. samp_q tracks the synchronised vector; db_cnt_q counts how
    // many consecutive cycles it has held the same value (saturating at
    // DB_CYCLES). Only a vector that has survived DB_CYCLES cycles is
    // promoted to stable_q.
    // -----------------------------------------------------------------------
    logic [3:0] samp_q;
    logic [7:0] db_cnt_q;
    logic [3:0] stable_q;
    logic [3:0] stable_last_q;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            samp_q        <= 4'b0000;
            db_cnt_q      <= 8'd0;
            stable_q      <= 4'b0000;
            stable_last_q <= 4'b0000;
        end else begin
            if (btn_s2_q != samp_q) begin
                samp_q   <= btn_s2_q;
                db_cnt_q <= 8'd1;
            end else if (db_cnt_q < DB8) begin
                db_cnt_q <= db_cnt_q + 8'd1;
            end
            if (db_cnt_q >= DB8) begin
                stable_q <= samp_q;
            end
            stable_last_q <= stable_q;
        end
    end

    // A press is the stable vector leaving all-zero. Going from one non-zero
    // vector to another does not re-arm; the buttons must be released first.
    logic press_evt;
    assign press_evt = (stable_last_q == 4'b0000) && (stable_q != 4'b0000);

    logic       one_hot;
    logic [1:0] enc;

    always_comb begin
        one_hot = 1'b1;
        enc     = 2'd0;
        unique case (stable_q)
            4'b0001: enc = 2'd0;
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Collection FSM
    // -----------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [BW-1:0] buf_q, buf_d;
    logic [3:0]    count_q, count_d;
    logic          bad_q, bad_d;
    logic          dv_q, dv_d;
    logic [1:0]    digit_q, digit_d;
    logic          inv_q, inv_d;
    logic          correct_q, correct_d;

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q   <= ST_IDLE;
            buf_q     <= '0;
            count_q   <= 4'd0;
            bad_q     <= 1'b0;
            dv_q      <= 1'b0;
            digit_q   <= 2'd0;
            inv_q     <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            bad_q     <= bad_d;
            dv_q      <= dv_d;
            digit_q   <= digit_d;
            inv_q     <= inv_d;
            correct_q <= correct_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        bad_d   = bad_q;
        dv_d    = 1'b0;
        digit_d = 2'd0;
        inv_d   = 1'b0;

        if (clr_s2_q) begin
            // Clear wins over any press arriving in the same cycle.
            buf_d   = '0;
            count_d = 4'd0;
            bad_d   = 1'b0;
            state_d = arm ? ST_COLLECT : ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    buf_d   = '0;
                    count_d = 4'd0;
                    bad_d   = 1'b0;
                    if (arm) begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!arm) begin
                        buf_d   = '0;
                        count_d = 4'd0;
                        bad_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else if (press_evt) begin
                        if (one_hot) begin
                            for (int i = 0; i < int'(CODE_LEN); i++) begin
                                if (count_q == 4'(i)) begin
                                    buf_d[2*i +: 2] = enc;
                                end
                            end
                            count_d = count_q + 4'd1;
                            dv_d    = 1'b1;
                            digit_d = enc;
                            if (count_d == LEN4) begin
                                state_d = ST_FULL;
                            end
                        end else begin
                            inv_d = 1'b1;
                            bad_d = 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    // Buffer frozen; presses ignored until arm drops.
                    if (!arm) begin
                        buf_d   = '0;
                        count_d = 4'd0;
                        bad_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    buf_d   = '0;
                    count_d = 4'd0;
                    bad_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Computed from next-state values so correct rises with seq_full.
    assign correct_d = (state_d == ST_FULL) && (buf_d == PW) && !bad_d;

    assign digit_valid   = dv_q;
    assign digit         = digit_q;
    assign invalid_press = inv_q;
    assign digit_count   = count_q;
    assign seq_full      = (state_q == ST_FULL);
    assign correct       = correct_q;
    assign state_dbg     = state_q;

endmodule
